hazard_stall_unit: RTL and testbench

- Producer-side companion to the forwarding logic in the two-slot VLIW pipeline. Slot 0 is the main instruction; slot c is the compressed instruction.
- Keeps a registered shadow of in-flight destination registers for the EX, MEM and WB stages.
- Detects hazards that forwarding cannot cover: load-use, and branch/jump operands resolved in ID. Drives stall, bubble and flush to the IF/ID and ID/EX registers.
- Also counts stall cycles and flags runaway stalls.

---
 rtl/hazard_stall_unit.sv | 98 +++++++++
 tb/tb_hazard_stall_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / ID-resolved control hazard detection with stall, bubble, flush and stall accounting.
module hazard_stall_unit #(
    parameter int MAX_STALL = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rsc,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_usec,
    input  logic             id_regwr,
    input  logic             id_regwrc,
    input  logic [4:0]       id_regdest,
    input  logic [4:0]       id_regdestc,
    input  logic             id_memrd,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             id_taken,
    input  logic             mem_wait,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             hazard_err
);
    localparam int RW = $clog2(MAX_STALL + 1);
    typedef struct packed {
        logic       wr;
        logic [4:0] dest;
        logic       wrc;
        logic [4:0] destc;
        logic       ld;
    } ent_t;
    typedef enum logic [1:0] {RUN, STALL, WAIT} state_t;

    ent_t [2:0]       sh_q, sh_d;
    ent_t             ex, mem, ex_new;
    state_t           state_q, state_d;
    logic [RW-1:0]    run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flush_q, flush_d, err_q, err_d;
    logic             vld, lu, ctl, haz, issue;

    function automatic logic hit(ent_t e, logic [4:0] r);
        return (r != 5'd0) && ((e.wr && e.dest == r) || (e.wrc && e.destc == r));
    endfunction

    // sh_q[0] is EX, [1] is MEM, [2] is WB
    assign ex  = sh_q[0];
    assign mem = sh_q[1];

    always_comb begin
        vld     = id_valid & ~flush_q;
        lu      = vld & ex.ld & ex.wr & (ex.dest != 5'd0) &
                  ((id_use1 & id_rs1 == ex.dest) | (id_use2 & id_rs2 == ex.dest) | (id_usec & id_rsc == ex.dest));
        ctl     = vld & ((id_jump & hit(ex, id_rs1)) | (id_branch & hit(ex, id_rsc)) |
                  (id_jump & mem.ld & mem.dest == id_rs1 & id_rs1 != 5'd0) |
                  (id_branch & mem.ld & mem.dest == id_rsc & id_rsc != 5'd0));
        haz     = lu | ctl;
        issue   = vld & ~haz;
        stall   = haz | mem_wait;
        bubble  = haz & ~mem_wait;
        ex_new  = issue ? {id_regwr, id_regdest, id_regwrc, id_regdestc, id_memrd & id_regwr} : '0;
        sh_d    = mem_wait ? sh_q : {sh_q[1:0], ex_new};
        flush_d = issue & id_taken & ~mem_wait;
        state_d = mem_wait ? WAIT : haz ? STALL : RUN;
        run_d   = state_d == RUN ? '0 : state_q == RUN ? RW'(1) :
                  run_q == RW'(MAX_STALL) ? run_q : run_q + RW'(1);
        err_d   = err_q | (state_d != RUN && run_d == RW'(MAX_STALL));
        cnt_d   = (stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q    <= '0;
            state_q <= RUN;
            run_q   <= '0;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            state_q <= state_d;
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign flush      = flush_q;
    assign stall_cnt  = cnt_q;
    assign hazard_err = err_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed and random stimulus checked against a history-queue model of the hazard rules.
module tb_hazard_stall_unit;
    localparam int MAX = 4;
    logic clk = 0, rst = 1;
    logic id_valid = 0, id_use1 = 0, id_use2 = 0, id_usec = 0, id_regwr = 0, id_regwrc = 0;
    logic id_memrd = 0, id_branch = 0, id_jump = 0, id_taken = 0, mem_wait = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rsc = 0, id_regdest = 0, id_regdestc = 0;
    logic stall, bubble, flush, hazard_err;
    logic [15:0] stall_cnt;

    typedef struct {bit wr; int dest; bit wrc; int destc; bit ld;} m_ent_t;
    m_ent_t pipe[$];
    bit m_flush, m_err;
    int m_cnt, m_run, checks, errors;

    hazard_stall_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rsc(id_rsc),
        .id_use1(id_use1), .id_use2(id_use2), .id_usec(id_usec), .id_regwr(id_regwr), .id_regwrc(id_regwrc),
        .id_regdest(id_regdest), .id_regdestc(id_regdestc), .id_memrd(id_memrd), .id_branch(id_branch),
        .id_jump(id_jump), .id_taken(id_taken), .mem_wait(mem_wait), .stall(stall), .bubble(bubble),
        .flush(flush), .stall_cnt(stall_cnt), .hazard_err(hazard_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit hit(m_ent_t e, int r);
        return r != 0 && ((e.wr && e.dest == r) || (e.wrc && e.destc == r));
    endfunction

    task automatic model_reset();
        m_ent_t z = '{default: 0};
        pipe = {z, z, z};
        m_flush = 0; m_err = 0; m_cnt = 0; m_run = 0;
    endtask

    task automatic drv(bit v, int r1, bit u1, int rc, bit uc, bit w, int d, bit wc, int dc,
                       bit ld, bit br, bit jp, bit tk, bit mw);
        id_valid = v; id_rs1 = 5'(r1); id_use1 = u1; id_rsc = 5'(rc); id_usec = uc;
        id_rs2 = 0; id_use2 = 0; id_regwr = w; id_regdest = 5'(d); id_regwrc = wc; id_regdestc = 5'(dc);
        id_memrd = ld; id_branch = br; id_jump = jp; id_taken = tk; mem_wait = mw;
    endtask

    // one cycle: predict, compare at the negedge, then advance the model on the posedge
    task automatic tick();
        bit vld, lu, ctl, haz, st;
        m_ent_t ex, mem, ne;
        ex = pipe[0]; mem = pipe[1];
        vld = id_valid && !m_flush;
        lu  = vld && ex.ld && ex.wr && ex.dest != 0 && ((id_use1 && id_rs1 == ex.dest) ||
              (id_use2 && id_rs2 == ex.dest) || (id_usec && id_rsc == ex.dest));
        ctl = vld && ((id_jump && hit(ex, id_rs1)) || (id_branch && hit(ex, id_rsc)) ||
              (id_jump && mem.ld && mem.dest == id_rs1 && id_rs1 != 0) ||
              (id_branch && mem.ld && mem.dest == id_rsc && id_rsc != 0));
        haz = lu || ctl;
        st  = haz || mem_wait;
        #4;
        chk("stall", stall, st);
        chk("bubble", bubble, haz && !mem_wait);
        chk("flush", flush, m_flush);
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("hazard_err", hazard_err, m_err);
        @(posedge clk);
        if (!mem_wait) begin
            ne = '{default: 0};
            if (vld && !haz) ne = '{id_regwr, id_regdest, id_regwrc, id_regdestc, id_memrd && id_regwr};
            pipe.push_front(ne);
            void'(pipe.pop_back());
        end
        m_flush = vld && !haz && id_taken && !mem_wait;
        if (st && m_cnt < 65535) m_cnt++;
        m_run = st ? m_run + 1 : 0;
        if (m_run >= MAX) m_err = 1;
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0); chk("rst_bubble", bubble, 0); chk("rst_flush", flush, 0);
        chk("rst_cnt", stall_cnt, 0); chk("rst_err", hazard_err, 0);
        rst = 0;
        // load x5 then ALU reading x5
        drv(1, 0,0, 0,0, 1,5, 0,0, 1, 0,0,0, 0); tick();
        drv(1, 5,1, 0,0, 1,6, 0,0, 0, 0,0,0, 0); tick(); tick();
        chk("lu_cnt", stall_cnt, 1);
        // compressed ALU producer x7 then branch on x7
        drv(1, 0,0, 0,0, 0,0, 1,7, 0, 0,0,0, 0); tick();
        drv(1, 0,0, 7,1, 0,0, 0,0, 0, 1,0,0, 0); tick(); tick();
        // load x7 then branch on x7: two bubbles
        drv(1, 0,0, 0,0, 1,7, 0,0, 1, 0,0,0, 0); tick();
        drv(1, 0,0, 7,1, 0,0, 0,0, 0, 1,0,0, 0); tick(); tick(); tick();
        chk("ld_br_cnt", stall_cnt, 4);
        // taken jump, then a load x9 that gets squashed, then a reader of x9
        drv(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 0); repeat (3) tick();
        drv(1, 1,1, 0,0, 0,0, 0,0, 0, 0,1,1, 0); tick();
        chk("flush_pulse", flush, 1);
        drv(1, 0,0, 0,0, 1,9, 0,0, 1, 0,0,0, 0); tick();
        chk("flush_end", flush, 0);
        drv(1, 9,1, 0,0, 0,0, 0,0, 0, 0,0,0, 0); tick();
        // x0 producer then x0 readers
        drv(1, 0,0, 0,0, 1,0, 0,0, 1, 0,0,0, 0); tick();
        drv(1, 0,1, 0,1, 0,0, 0,0, 0, 1,1,0, 0); tick();
        chk("x0_cnt", stall_cnt, 4);
        // six cycles of mem_wait
        drv(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 1); repeat (3) tick();
        chk("err_pre", hazard_err, 0);
        tick();
        chk("err_4th", hazard_err, 1);
        repeat (2) tick();
        drv(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 0); tick();
        chk("err_sticky", hazard_err, 1);
        chk("mw_cnt", stall_cnt, 10);
        // load x3, jump on x3 under mem_wait, then release
        drv(1, 0,0, 0,0, 1,3, 0,0, 1, 0,0,0, 0); tick();
        drv(1, 3,1, 0,0, 0,0, 0,0, 0, 0,1,0, 1); repeat (3) tick();
        drv(1, 3,1, 0,0, 0,0, 0,0, 0, 0,1,0, 0); repeat (3) tick();
        chk("ld_jmp_cnt", stall_cnt, 15);
        // random traffic on a small register set to provoke many hazards
        for (int i = 0; i < 400; i++) begin
            drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0);
            id_rs2 = 5'($urandom_range(0, 3)); id_use2 = 1'($urandom_range(0, 1));
            tick();
        end
        // asynchronous reset in the middle of a load-use stall
        drv(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 0); repeat (2) tick();
        drv(1, 0,0, 0,0, 1,5, 0,0, 1, 0,0,0, 0); tick();
        drv(1, 5,1, 0,0, 0,0, 0,0, 0, 0,0,1, 0);
        #1;
        chk("pre_rst_stall", stall, 1);
        rst = 1; id_valid = 0;
        #1;
        chk("arst_stall", stall, 0); chk("arst_bubble", bubble, 0); chk("arst_flush", flush, 0);
        chk("arst_cnt", stall_cnt, 0); chk("arst_err", hazard_err, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        drv(0, 0,0, 0,0, 0,0, 0,0, 0, 0,0,0, 0); repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
